// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding, bytes-per-word derivation and the
// word-to-byte address shift that the fetch path also uses.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Word index lives in addr[31:2] on both the write and fetch side.
  localparam int WADDR_SHIFT = 2;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream into the loader: valid/ready handshake, a byte moves when both are high.
interface imem_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_word_packer.sv
// Collects little-endian bytes into a word; word/word_full are combinational on the
// byte that completes the word. No backpressure of its own: byte_en is an accepted transfer.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             byte_en,
  input  logic [7:0]       byte_data,
  output logic [WIDTH-1:0] word,
  output logic             word_full
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]    byte_cnt;
  logic [WIDTH-1:0] lanes;

  // Current byte is merged in combinationally so the completed word is usable on its final transfer.
  always_comb begin
    word = lanes;
    for (int i = 0; i < BPW; i++) begin
      if (byte_cnt == CW'(i)) begin
        word[i*8 +: 8] = byte_data;
      end
    end
  end

  assign word_full = byte_en && (byte_cnt == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      lanes    <= '0;
    end else if (clr) begin
      byte_cnt <= '0;
    end else if (byte_en) begin
      lanes    <= word;
      byte_cnt <= word_full ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Programs the instruction RAM from a framed byte stream (16-bit LE word count, then data);
// we fires the cycle after a word's last byte, byte_ready drops during WRITE and outside frames.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int IDXW = $clog2(LENGTH) + 1;

  state_t           state, state_next;
  logic [15:0]      len;
  logic [IDXW-1:0]  word_idx;
  logic             xfer;
  logic [15:0]      len_full;
  logic [15:0]      idx_next16;
  logic [WIDTH-1:0] packed_word;
  logic             word_full;
  logic             accept_start;
  logic             pack_en;

  assign xfer       = bus.byte_valid & bus.byte_ready;
  assign len_full   = {bus.byte_data, len[7:0]};
  assign idx_next16 = 16'(word_idx) + 16'd1;

  imem_word_packer #(.WIDTH(WIDTH)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept_start),
    .byte_en   (pack_en),
    .byte_data (bus.byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_start = 1'b0;
    pack_en      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next   = ST_LEN_LO;
          accept_start = 1'b1;
        end
      end
      ST_LEN_LO: if (xfer) state_next = ST_LEN_HI;
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)              state_next = ST_DONE;
          else if (len_full > 16'(LENGTH))    state_next = ST_ERR;
          else                                state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        pack_en = xfer;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: state_next = (idx_next16 == len) ? ST_DONE : ST_DATA;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake and status are pure decodes of the state register.
  assign bus.byte_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
  assign we             = (state == ST_WRITE);
  assign busy           = bus.byte_ready || we;
  assign done           = (state == ST_DONE);
  assign err            = (state == ST_ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      word_idx <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      if (accept_start) word_idx <= '0;
      if (state == ST_LEN_LO && xfer) len[7:0]  <= bus.byte_data;
      if (state == ST_LEN_HI && xfer) len[15:8] <= bus.byte_data;
      // Capture on the completing byte so waddr/wdata hold steady through WRITE and after.
      if (word_full) begin
        wdata <= packed_word;
        waddr <= 32'(word_idx) << WADDR_SHIFT;
      end
      if (state == ST_WRITE) word_idx <= word_idx + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: frame-level reference model feeds an expected-write
// queue, a negedge monitor checks every we pulse against it.
module tb_imem_loader;

  localparam int LENGTH = 8;
  localparam int WIDTH  = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             we;
  logic [31:0]      waddr;
  logic [WIDTH-1:0] wdata;
  logic             busy, done, err;

  imem_loader_if bus();

  imem_loader #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  we_count = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_t e;
      we_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_we: got waddr=%0h wdata=%0h expected no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 64'(waddr), 64'(e.addr));
        chk("wdata", 64'(wdata), 64'(e.data));
        chk("ready_during_we", 64'(bus.byte_ready), 64'd0);
      end
    end
  end

  // Frame-level model: returns 0 for a completed load, 1 for a rejected length.
  task automatic model(input bq_t fr, output int outcome);
    int          n;
    logic [31:0] w;
    n = int'(fr[0]) + 256 * int'(fr[1]);
    if (n == 0) outcome = 0;
    else if (n > LENGTH) outcome = 1;
    else begin
      outcome = 0;
      for (int i = 0; i < n; i++) begin
        w = 32'd0;
        for (int b = 0; b < 4; b++) w = w + (32'(fr[2 + 4*i + b]) << (8*b));
        exp_q.push_back('{addr: 32'(4*i), data: w});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    int waited;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (gap) @(posedge clk);
    #1;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.byte_ready || waited >= 200) break;
      waited++;
    end
    chk("byte_accept_timeout", 64'(waited >= 200), 64'd0);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic drive_junk(input int cycles);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      bus.byte_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(done || err) && c < 500);
    chk("end_timeout", 64'(c >= 500), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_frame(input bq_t fr, input int maxgap, input int start_mid);
    int outcome;
    int n_before;
    n_before = we_count;
    model(fr, outcome);
    pulse_start();
    send_byte(fr[0], maxgap);
    send_byte(fr[1], maxgap);
    if (outcome == 1) begin
      drive_junk(6);
    end else begin
      for (int k = 2; k < fr.size(); k++) begin
        send_byte(fr[k], maxgap);
        if (k - 2 == start_mid) pulse_start();
      end
    end
    wait_end();
    repeat (2) @(posedge clk);
    #1;
    chk("done", 64'(done), 64'(outcome == 0));
    chk("err", 64'(err), 64'(outcome == 1));
    chk("busy", 64'(busy), 64'd0);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("we_pulses", 64'(we_count - n_before),
        64'((outcome == 0) ? (fr.size() - 2) / 4 : 0));
  endtask

  function automatic bq_t rand_frame(input int n);
    bq_t fr;
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    if (n <= LENGTH) begin
      for (int i = 0; i < 4*n; i++) fr.push_back(8'($urandom));
    end
    return fr;
  endfunction

  function automatic bq_t test1_frame();
    bq_t fr;
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
    return fr;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word program at full byte rate
    do_frame(test1_frame(), 0, -1);
    // Empty program
    fr = '{8'h00, 8'h00};
    do_frame(fr, 0, -1);
    // Oversized lengths, including one only the high byte rejects
    fr = '{8'h09, 8'h00};
    do_frame(fr, 0, -1);
    fr = '{8'h01, 8'h01};
    do_frame(fr, 0, -1);
    // Gappy source
    do_frame(test1_frame(), 5, -1);
    // Start pulse while loading
    do_frame(test1_frame(), 0, 1);
    // Exactly LENGTH words
    do_frame(rand_frame(LENGTH), 2, -1);

    // Reset part-way through a load
    begin
      int outcome;
      fr = rand_frame(2);
      model(fr, outcome);
      pulse_start();
      for (int k = 0; k < 7; k++) send_byte(fr[k], 0);
      rst_n = 1'b0;
      #1;
      chk("arst_we", 64'(we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      chk("arst_ready", 64'(bus.byte_ready), 64'd0);
      chk("arst_waddr", 64'(waddr), 64'd0);
      chk("arst_wdata", 64'(wdata), 64'd0);
      chk("arst_pending", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_frame(rand_frame(3), 1, -1);
    end

    for (int r = 0; r < 8; r++) begin
      do_frame(rand_frame(int'($urandom_range(0, 10))), 3, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
